collision_check: RTL and testbench
==================================

# collision_check

Downstream consumer of the player record and the obstacle records. Once per game tick it snapshots the player and all obstacle slots. It then walks the slots sequentially, one per clock, and tests axis-aligned bounding-box overlap. On the first overlap it latches a sticky `hit` (game over) and the index of the offending slot. The game-over/score logic and display freeze are driven from `hit` and `done`.

## Interface
- `NOBJ`, default 4: number of obstacle slots on `obstacles`; 1..16.
- `IDXW`, default 4: width of `hit_idx`; must satisfy 2^IDXW ≥ NOBJ.
- `EMPTYTYPE`, default 0: type-field value marking an unused slot.
- `clk` input 1: single clock, all state on rising edge.
- `reset` input 1: synchronous, active-high; one clock at reset sets all state to the reset values below.
- `pause` input 1: high = freeze; all state holds, `tick` ignored.
- `tick` input 1: one-cycle pulse per game frame; starts a scan.
- `player` input `datalen`: player record in `define.v` field layout (type/x/y/width/height).
- `obstacles` input NOBJ×`datalen`: slot i occupies bits [i×`datalen` +: `datalen`].
- `busy` output 1: high while scanning.
- `done` output 1: one-cycle pulse, scan finished (hit or not).
- `hit` output 1: sticky collision flag.
- `hit_idx` output IDXW: slot index of first detected collision.
- `overrun` output 1: sticky; `tick` arrived while busy.

## Operation
- State: IDLE, SCAN, HALT. Reset → IDLE; `busy`=0, `done`=0, `hit`=0, `hit_idx`=0, `overrun`=0, slot index=0.
- IDLE: `tick`=1 and `pause`=0 → latch `player` and the full `obstacles` bus into snapshot registers, index←0, → SCAN. Inputs may change freely afterwards.
- SCAN, evaluating slot i from the snapshot:
  - If type == EMPTYTYPE, the slot never hits.
  - Otherwise overlap = (px < ox+ow) && (ox < px+pw) && (py < oy+oh) && (oy < py+ph).
  - All sums are formed one bit wider than the position field; there is no wrap.
  - Touching edges (px+pw == ox) do not overlap.
  - On overlap: `hit`←1, `hit_idx`←i, `done`←1, → HALT.
  - Else, if i == NOBJ−1: `done`←1, → IDLE.
  - Else: i←i+1.
- HALT: `tick` ignored, no scans run, `hit` and `hit_idx` hold. Exit only by `reset`.
- `done` is cleared on every clock in which it was not set.
- `tick` while in SCAN: ignored, `overrun`←1. `overrun` stays set until `reset`.
- `pause`=1: all registers hold, including snapshot, index, and `done`. A `tick` during pause is dropped and does not set `overrun`.
- `reset` mid-scan: immediate return to IDLE with all reset values; no `done` pulse.
- `reset` and `tick` on the same edge: `reset` wins.

## Timing
- Tick sampled at edge E0, with `busy` high from E0.
- Hit at slot k: `done`, `hit`, and `hit_idx` become visible after edge E(k+1). Latency is k+1 clocks.
- No hit: `done` becomes visible after E(NOBJ) and `busy` falls at the same edge. Latency is NOBJ clocks.
- Each paused clock adds exactly one clock of latency.
- A new `tick` is accepted on the clock right after the `done` edge (back-to-back scans).
- Combinational path per clock: one slot compare. Obstacle slot mux driven by the registered index.

## Test plan
- Reset, then tick with player x=20 y=0 w=10 h=12 and all slots empty -> `done` after 4 clocks, `hit`=0, `busy` high for 4 clocks.
- Obstacle in slot 2 at x=25 y=0 w=8 h=10, player as above -> `done` after 3 clocks, `hit`=1, `hit_idx`=2. A later tick produces no scan.
- Touching edge (obstacle x=30, player x=20 w=10) -> no hit. Player lifted to y=12 over obstacle h=12 -> no hit. Obstacle h=13 -> hit.
- Overlapping obstacles in slots 1 and 3 -> `hit_idx`=1.
- Second tick during a scan -> `overrun`=1 and the scan result is unchanged. Pause held 3 clocks mid-scan -> `done` delayed exactly 3 clocks.
- Reset asserted during slot 1 of a scan that would hit at slot 2 -> no `done` pulse, `hit`=0. A new tick then scans cleanly and hits at slot 2.
- Obstacle x near field maximum with w=255 -> sum computed without wrap, correct no-hit result.

Source files
------------

// File: rtl/collision_check.sv
`default_nettype none
// ============================================================================
// Module      : collision_check
// Description : Per-tick sequential AABB overlap scan of a player record
//               against NOBJ obstacle slots; sticky hit with first slot index.
// Revision    : 1.0 - initial release
// ============================================================================
// Record layout, MSB to LSB: type[TYPEW] | x[POSW] | y[POSW] | width[SIZEW] | height[SIZEW]
module collision_check #(
  parameter int NOBJ      = 4,
  parameter int IDXW      = 4,
  parameter int EMPTYTYPE = 0,
  localparam int TYPEW    = 4,
  localparam int POSW     = 8,
  localparam int SIZEW    = 8,
  localparam int DATALEN  = TYPEW + 2*POSW + 2*SIZEW
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    pause,
  input  logic                    tick,
  input  logic [DATALEN-1:0]      player,
  input  logic [NOBJ*DATALEN-1:0] obstacles,
  output logic                    busy,
  output logic                    done,
  output logic                    hit,
  output logic [IDXW-1:0]         hit_idx,
  output logic                    overrun
);

  localparam int C_H_LSB = 0;
  localparam int C_W_LSB = SIZEW;
  localparam int C_Y_LSB = 2*SIZEW;
  localparam int C_X_LSB = 2*SIZEW + POSW;
  localparam int C_T_LSB = 2*SIZEW + 2*POSW;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_HALT = 2'd2
  } state_t;

  state_t                   r_state, w_state_nx;
  logic [IDXW-1:0]          r_idx, w_idx_nx;
  logic                     r_done, w_done_nx;
  logic                     r_hit, w_hit_nx;
  logic [IDXW-1:0]          r_hit_idx, w_hit_idx_nx;
  logic                     r_overrun, w_overrun_nx;
  logic                     w_load;
  logic [DATALEN-TYPEW-1:0] r_player;
  logic [DATALEN-1:0]       r_obs [NOBJ];
  logic [DATALEN-1:0]       w_slot;
  logic                     w_unused_ptype;

  // The player's type field plays no part in the overlap test.
  assign w_unused_ptype = ^player[C_T_LSB +: TYPEW];

  always_comb begin
    w_slot = '0;
    for (int i = 0; i < NOBJ; i++) begin
      if (r_idx == IDXW'(i)) w_slot = r_obs[i];
    end
  end

  logic [POSW:0] w_px, w_py, w_ox, w_oy, w_pxe, w_pye, w_oxe, w_oye;
  logic          w_empty, w_overlap;

  // Extents are one bit wider than a position so that far edges never wrap.
  assign w_px  = {1'b0, r_player[C_X_LSB +: POSW]};
  assign w_py  = {1'b0, r_player[C_Y_LSB +: POSW]};
  assign w_ox  = {1'b0, w_slot[C_X_LSB +: POSW]};
  assign w_oy  = {1'b0, w_slot[C_Y_LSB +: POSW]};
  assign w_pxe = w_px + {1'b0, r_player[C_W_LSB +: SIZEW]};
  assign w_pye = w_py + {1'b0, r_player[C_H_LSB +: SIZEW]};
  assign w_oxe = w_ox + {1'b0, w_slot[C_W_LSB +: SIZEW]};
  assign w_oye = w_oy + {1'b0, w_slot[C_H_LSB +: SIZEW]};

  assign w_empty   = (w_slot[C_T_LSB +: TYPEW] == TYPEW'(EMPTYTYPE));
  assign w_overlap = !w_empty && (w_px < w_oxe) && (w_ox < w_pxe) &&
                     (w_py < w_oye) && (w_oy < w_pye);

  always_comb begin
    w_state_nx   = r_state;
    w_idx_nx     = r_idx;
    w_done_nx    = 1'b0;
    w_hit_nx     = r_hit;
    w_hit_idx_nx = r_hit_idx;
    w_overrun_nx = r_overrun;
    w_load       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (tick) begin
          w_load     = 1'b1;
          w_idx_nx   = '0;
          w_state_nx = S_SCAN;
        end
      end
      S_SCAN: begin
        if (tick) w_overrun_nx = 1'b1;
        if (w_overlap) begin
          w_hit_nx     = 1'b1;
          w_hit_idx_nx = r_idx;
          w_done_nx    = 1'b1;
          w_state_nx   = S_HALT;
        end else if (r_idx == IDXW'(NOBJ-1)) begin
          w_done_nx  = 1'b1;
          w_state_nx = S_IDLE;
        end else begin
          w_idx_nx = r_idx + 1'b1;
        end
      end
      S_HALT: begin
        w_state_nx = S_HALT;
      end
      default: begin
        w_state_nx = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_idx     <= '0;
      r_done    <= 1'b0;
      r_hit     <= 1'b0;
      r_hit_idx <= '0;
      r_overrun <= 1'b0;
      r_player  <= '0;
      for (int i = 0; i < NOBJ; i++) r_obs[i] <= '0;
    end else if (!pause) begin
      r_state   <= w_state_nx;
      r_idx     <= w_idx_nx;
      r_done    <= w_done_nx;
      r_hit     <= w_hit_nx;
      r_hit_idx <= w_hit_idx_nx;
      r_overrun <= w_overrun_nx;
      if (w_load) begin
        r_player <= player[DATALEN-TYPEW-1:0];
        for (int i = 0; i < NOBJ; i++) r_obs[i] <= obstacles[i*DATALEN +: DATALEN];
      end
    end
  end

  assign busy    = (r_state == S_SCAN);
  assign done    = r_done;
  assign hit     = r_hit;
  assign hit_idx = r_hit_idx;
  assign overrun = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_collision_check.sv
`default_nettype none
// Scoreboarded random + directed bench for collision_check against a
// first-overlapping-slot reference model.
module tb_collision_check;
  localparam int NOBJ = 4;
  localparam int IDXW = 4;
  localparam int DL   = 36;

  typedef struct {int t; int x; int y; int w; int h;} rec_t;
  typedef struct {int cyc; int hit; int idx;} exp_t;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              pause = 1'b0;
  logic              tick = 1'b0;
  logic [DL-1:0]     player = '0;
  logic [NOBJ*DL-1:0] obstacles = '0;
  logic              busy, done, hit, overrun;
  logic [IDXW-1:0]   hit_idx;

  collision_check #(.NOBJ(NOBJ), .IDXW(IDXW), .EMPTYTYPE(0)) dut (
    .clk(clk), .reset(reset), .pause(pause), .tick(tick),
    .player(player), .obstacles(obstacles),
    .busy(busy), .done(done), .hit(hit), .hit_idx(hit_idx), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  exp_t q[$];
  int   m_halt = 0, m_hit = 0, m_idx = 0, m_ovr = 0;

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", nm, act, req, cyc);
    end
  endtask

  function automatic logic [DL-1:0] pack(input rec_t r);
    return {4'(r.t), 8'(r.x), 8'(r.y), 8'(r.w), 8'(r.h)};
  endfunction

  // Reference: first non-empty slot whose box strictly overlaps the player.
  function automatic void model(input rec_t p, input rec_t obs [NOBJ],
                                output int h, output int idx, output int lat);
    h = 0; idx = 0; lat = NOBJ;
    for (int i = 0; i < NOBJ; i++) begin
      if (obs[i].t != 0 && p.x < obs[i].x + obs[i].w && obs[i].x < p.x + p.w &&
          p.y < obs[i].y + obs[i].h && obs[i].y < p.y + p.h) begin
        h = 1; idx = i; lat = i + 1;
        return;
      end
    end
  endfunction

  function automatic rec_t rnd_rec();
    rec_t r;
    r.t = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 15);
    r.x = $urandom_range(0, 63);
    r.y = $urandom_range(0, 63);
    r.w = $urandom_range(1, 24);
    r.h = $urandom_range(1, 24);
    return r;
  endfunction

  function automatic rec_t mk(input int t, input int x, input int y, input int w, input int h);
    rec_t r;
    r.t = t; r.x = x; r.y = y; r.w = w; r.h = h;
    return r;
  endfunction

  // Monitor: one sample per clock, 1 time unit after the rising edge.
  initial begin
    forever begin
      exp_t e;
      @(posedge clk);
      #1;
      cyc++;
      if (done) begin
        if (q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = q.pop_front();
          chk("done_cycle", cyc, e.cyc);
          chk("hit_at_done", int'(hit), e.hit);
          chk("hit_idx_at_done", int'(hit_idx), e.idx);
          chk("busy_at_done", int'(busy), 0);
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    q.delete();
    m_halt = 0; m_hit = 0; m_idx = 0; m_ovr = 0;
  endtask

  task automatic drive(input rec_t p, input rec_t obs [NOBJ]);
    player = pack(p);
    for (int i = 0; i < NOBJ; i++) obstacles[i*DL +: DL] = pack(obs[i]);
  endtask

  // poff/plen: pause window in negedges after the tick edge; ooff: extra tick.
  task automatic run_scan(input rec_t p, input rec_t obs [NOBJ],
                          input int poff, input int plen, input int ooff);
    exp_t e;
    int   h, idx, lat, scan;
    rec_t junk [NOBJ];
    @(negedge clk);
    drive(p, obs);
    tick = 1'b1;
    scan = !m_halt;
    if (scan != 0) begin
      model(p, obs, h, idx, lat);
      e.cyc = cyc + 1 + lat + plen;
      e.hit = h;
      e.idx = idx;
      q.push_back(e);
      if (ooff > 0) m_ovr = 1;
      if (h != 0) begin m_halt = 1; m_hit = 1; m_idx = idx; end
    end
    @(negedge clk);
    tick = 1'b0;
    for (int i = 0; i < NOBJ; i++) junk[i] = rnd_rec();
    drive(rnd_rec(), junk);
    if (scan != 0) chk("busy_after_tick", int'(busy), 1);
    for (int k = 1; k <= 80; k++) begin
      if (q.size() == 0 && k > NOBJ + 1 && k > poff + plen && k > ooff) break;
      pause = (plen > 0 && k >= poff && k < poff + plen);
      tick  = (k == ooff) || (plen > 0 && k == poff);
      @(negedge clk);
    end
    pause = 1'b0;
    tick  = 1'b0;
    if (q.size() != 0) begin
      chk("scan_timeout", q.size(), 0);
      q.delete();
    end
    chk("hit_after", int'(hit), m_hit);
    chk("hit_idx_after", int'(hit_idx), m_idx);
    chk("overrun_after", int'(overrun), m_ovr);
    chk("busy_after", int'(busy), 0);
  endtask

  rec_t pl;
  rec_t ob [NOBJ];

  task automatic clear_obs();
    for (int i = 0; i < NOBJ; i++) ob[i] = mk(0, 0, 0, 0, 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_hit", int'(hit), 0);
    chk("rst_hit_idx", int'(hit_idx), 0);
    chk("rst_overrun", int'(overrun), 0);

    // All empty slots, then a single hit at slot 2 followed by an ignored tick.
    pl = mk(1, 20, 0, 10, 12);
    clear_obs();
    run_scan(pl, ob, 0, 0, 0);
    ob[2] = mk(2, 25, 0, 8, 10);
    run_scan(pl, ob, 0, 0, 0);
    run_scan(pl, ob, 0, 0, 0);
    do_reset();

    // Edge-touching and vertical-separation boundaries.
    clear_obs();
    ob[1] = mk(3, 30, 0, 8, 10);
    run_scan(pl, ob, 0, 0, 0);
    pl = mk(1, 20, 12, 10, 12);
    ob[1] = mk(3, 25, 0, 8, 12);
    run_scan(pl, ob, 0, 0, 0);
    ob[1] = mk(3, 25, 0, 8, 13);
    run_scan(pl, ob, 0, 0, 0);
    do_reset();

    // First of two overlapping slots wins.
    pl = mk(1, 20, 0, 10, 12);
    clear_obs();
    ob[1] = mk(1, 22, 2, 4, 4);
    ob[3] = mk(1, 18, 0, 5, 5);
    run_scan(pl, ob, 0, 0, 0);
    do_reset();

    // Overrun tick mid-scan, then a pause of 3 clocks carrying a dropped tick.
    clear_obs();
    ob[2] = mk(2, 25, 0, 8, 10);
    run_scan(pl, ob, 0, 0, 1);
    do_reset();
    clear_obs();
    run_scan(pl, ob, 2, 3, 0);

    // Reset while slot 1 is being evaluated kills the scan without done.
    ob[2] = mk(2, 25, 0, 8, 10);
    @(negedge clk);
    drive(pl, ob);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    q.delete();
    m_halt = 0; m_hit = 0; m_idx = 0; m_ovr = 0;
    repeat (NOBJ + 3) @(negedge clk);
    chk("midreset_hit", int'(hit), 0);
    chk("midreset_busy", int'(busy), 0);
    run_scan(pl, ob, 0, 0, 0);
    do_reset();

    // Far-edge sums that would wrap in position width.
    clear_obs();
    ob[0] = mk(1, 250, 0, 255, 10);
    run_scan(pl, ob, 0, 0, 0);
    pl = mk(1, 250, 0, 5, 5);
    ob[0] = mk(0, 0, 0, 0, 0);
    ob[3] = mk(1, 200, 0, 255, 10);
    run_scan(pl, ob, 0, 0, 0);
    do_reset();
    pl = mk(1, 250, 0, 10, 5);
    clear_obs();
    ob[1] = mk(1, 255, 0, 1, 5);
    run_scan(pl, ob, 0, 0, 0);
    do_reset();

    // Randomized scans, occasionally paused right after the tick.
    for (int n = 0; n < 40; n++) begin
      int pl_len;
      pl = rnd_rec();
      pl.t = 1;
      for (int i = 0; i < NOBJ; i++) ob[i] = rnd_rec();
      pl_len = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
      run_scan(pl, ob, 1, pl_len, 0);
      if (m_halt != 0) do_reset();
    end

    repeat (4) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
